// File: rtl/mem_pkg.sv
// Shared types, default widths and helpers for the memory controller.
package mem_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_LEN_W  = 3;
    localparam int DEF_COUNT  = 4096;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RD_DRAIN
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
    } req_t;

    function automatic logic addr_in_range(input logic [DEF_ADDR_W-1:0] a, input int count);
        return int'(a) < count;
    endfunction
endpackage

// File: rtl/addr_gen.sv
// Wrapping beat address counter with load, increment and last-beat detect,
// shared by the write and read paths of mem_ctrl.
module addr_gen
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int COUNT  = DEF_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_cur,
    output logic              o_last
);
    localparam int                CNT_W     = LEN_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT - 1);

    logic [ADDR_W-1:0] r_cur;
    logic [CNT_W-1:0]  r_left;
    logic [ADDR_W-1:0] w_base;
    logic [CNT_W-1:0]  w_left;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // Load and step together issue the first beat in the same cycle.
    assign w_base = i_load ? i_start : r_cur;
    assign w_left = i_load ? (CNT_W'(i_len) + CNT_W'(1)) : r_left;

    // NOTE: flops use non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur  <= '0;
            r_left <= '0;
        end else if (i_load || i_step) begin
            r_cur  <= i_step ? wrap_inc(w_base) : w_base;
            r_left <= i_step ? (w_left - 1'b1) : w_left;
        end
    end

    assign o_cur  = r_cur;
    assign o_last = (r_left == CNT_W'(1));
endmodule

// File: rtl/mem_ctrl.sv
// Initiator-side burst controller: turns core load/store requests into
// single-port synchronous memory cycles with 1-cycle read latency.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COUNT  = DEF_COUNT,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            r_state;
    state_t            w_next;
    req_t              w_req;
    logic              r_ready_en;
    logic              r_rd_pend;
    logic              r_rd_pend_last;
    logic              r_rdata_valid;
    logic              r_rdata_last;
    logic              r_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_load;
    logic              w_step;
    logic              w_issue_rd;
    logic              w_issue_wr;
    logic              w_reject;
    logic              w_last;
    logic              w_gen_last;
    logic [ADDR_W-1:0] w_cur;
    logic [ADDR_W-1:0] w_issue_addr;

    assign w_req = '{we: req_we, addr: req_addr, len: req_len};

    addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .COUNT (COUNT)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_start(w_req.addr),
        .i_len  (w_req.len),
        .o_cur  (w_cur),
        .o_last (w_gen_last)
    );

    // In IDLE the first read beat is issued straight from the request.
    assign w_last       = (r_state == IDLE) ? (w_req.len == '0) : w_gen_last;
    assign w_issue_addr = (r_state == IDLE) ? w_req.addr : w_cur;

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        w_reject   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_ready_en) begin
                    if (!addr_in_range(w_req.addr, COUNT)) begin
                        w_reject = 1'b1;
                    end else begin
                        w_load = 1'b1;
                        if (w_req.we) begin
                            w_next = WR;
                        end else begin
                            w_step     = 1'b1;
                            w_issue_rd = 1'b1;
                            w_next     = w_last ? RD_DRAIN : RD;
                        end
                    end
                end
            end
            WR: begin
                if (wdata_valid) begin
                    w_step     = 1'b1;
                    w_issue_wr = 1'b1;
                    if (w_last) w_next = IDLE;
                end
            end
            RD: begin
                w_step     = 1'b1;
                w_issue_rd = 1'b1;
                if (w_last) w_next = RD_DRAIN;
            end
            RD_DRAIN: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ready_en     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_rdata_valid  <= 1'b0;
            r_rdata_last   <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ready_en <= 1'b1;
            r_mem_we   <= w_issue_wr;
            if (w_issue_wr || w_issue_rd) r_mem_addr <= w_issue_addr;
            if (w_issue_wr) r_mem_wdata <= wdata;
            // Read data appears one cycle after its address; valid tracks that delay.
            r_rd_pend      <= w_issue_rd;
            r_rd_pend_last <= w_issue_rd && w_last;
            r_rdata_valid  <= r_rd_pend;
            r_rdata_last   <= r_rd_pend_last;
            r_err          <= w_reject;
        end
    end

    assign req_ready   = r_ready_en && (r_state == IDLE);
    assign wdata_ready = (r_state == WR);
    assign busy        = (r_state != IDLE);
    assign err         = r_err;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;
    assign rdata       = mem_rdata;
    assign rdata_valid = r_rdata_valid;
    assign rdata_last  = r_rdata_last;
endmodule
